// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the fetch stage.
package rv_fetch_pkg;

    // Instructions fetched per issue slot.
    localparam int unsigned FETCH_WIDTH = 2;

    // Canonical NOP (addi x0, x0, 0) used by decode to fill invalid slots.
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One queued instruction tagged with its byte PC.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Byte PC to instruction memory word index.
    function automatic logic [31:0] word_index(input logic [31:0] byte_pc);
        return {2'b00, byte_pc[31:2]};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-in / two-out circular buffer of PC-tagged instructions.
// Pushes always arrive as a pair; the producer guarantees space, so there is no overflow path.
module fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int unsigned  DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry0,
    input  fetch_entry_t push_entry1,
    input  logic [1:0]   pop_cnt,
    output fetch_entry_t head0,
    output fetch_entry_t head1,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_nxt, wr_ptr_nxt;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] pop_req;
    logic [CW-1:0] pop_num;
    logic          do_push;

    assign do_push    = push & ~flush;
    assign rd_ptr_nxt = rd_ptr_q + PW'(1);
    assign wr_ptr_nxt = wr_ptr_q + PW'(1);

    // Pop count: clamp request to 2, then to what was queued before this edge's push.
    always_comb begin
        pop_req = CW'(0);
        unique case (pop_cnt)
            2'd0:    pop_req = CW'(0);
            2'd1:    pop_req = CW'(1);
            default: pop_req = CW'(2);
        endcase
        pop_num = (pop_req > count_q) ? count_q : pop_req;
    end

    // Next pointers and occupancy; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_num);
            wr_ptr_d = wr_ptr_q + (do_push ? PW'(2) : PW'(0));
            count_d  = count_q + (do_push ? CW'(2) : CW'(0)) - pop_num;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q]   <= push_entry0;
            mem_q[wr_ptr_nxt] <= push_entry1;
        end
    end

    assign head0 = mem_q[rd_ptr_q];
    assign head1 = mem_q[rd_ptr_nxt];
    assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues paired word reads to a 1-cycle instruction memory,
// queues the returned pair with PC tags and presents up to two instructions to decode.
module instr_fetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int unsigned  QUEUE_DEPTH = 8,
    parameter logic [31:0]  RESET_PC    = DEFAULT_RESET_PC,
    localparam int unsigned CW          = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_en,
    output logic [31:0]   imem_addr0,
    output logic [31:0]   imem_addr1,
    input  logic [31:0]   imem_data0,
    input  logic [31:0]   imem_data1,
    input  logic          stall,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic [1:0]    deq_cnt,
    output logic          out_valid0,
    output logic [31:0]   out_instr0,
    output logic [31:0]   out_pc0,
    output logic          out_valid1,
    output logic [31:0]   out_instr1,
    output logic [31:0]   out_pc1,
    output logic [CW-1:0] q_count
);

    // Issue only while the queue can absorb this pair on top of everything already promised.
    localparam logic [CW:0] RESERVE_LIMIT = (CW + 1)'(QUEUE_DEPTH - FETCH_WIDTH);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic         inflight_q, inflight_d;
    logic [CW:0]  reserved;
    logic         issue;
    logic         push;
    fetch_entry_t push_entry0, push_entry1;
    fetch_entry_t head0, head1;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Issue decision: queued entries plus the pair still in flight count against capacity.
    always_comb begin
        reserved = {1'b0, q_count} + (CW + 1)'({inflight_q, 1'b0});
        issue    = reset & ~stall & ~redirect_valid & (reserved <= RESERVE_LIMIT);
    end

    assign imem_en    = issue;
    assign imem_addr0 = word_index(pc_q);
    assign imem_addr1 = imem_addr0 + 32'd1;

    // Next PC / in-flight tracking; redirect overrides everything and drops the in-flight pair.
    always_comb begin
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (issue) begin
            pc_d       = pc_q + 32'd8;
            inflight_d = 1'b1;
            resp_pc_d  = pc_q;
        end
    end

    // PC and response-tracking registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // Memory data is only meaningful the cycle after an issue.
    always_comb begin
        push              = inflight_q & ~redirect_valid;
        push_entry0.instr = imem_data0;
        push_entry0.pc    = resp_pc_q;
        push_entry1.instr = imem_data1;
        push_entry1.pc    = resp_pc_q + 32'd4;
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .reset       (reset),
        .flush       (redirect_valid),
        .push        (push),
        .push_entry0 (push_entry0),
        .push_entry1 (push_entry1),
        .pop_cnt     (deq_cnt),
        .head0       (head0),
        .head1       (head1),
        .count       (q_count)
    );

    // Decode-facing outputs, zeroed when the slot is empty.
    always_comb begin
        out_valid0 = (q_count != '0);
        out_valid1 = (q_count >= CW'(2));
        out_instr0 = out_valid0 ? head0.instr : 32'd0;
        out_pc0    = out_valid0 ? head0.pc    : 32'd0;
        out_instr1 = out_valid1 ? head1.instr : 32'd0;
        out_pc1    = out_valid1 ? head1.pc    : 32'd0;
    end

endmodule
